// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing and a
// saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [2:0]    id_aluS,
  input  logic          id_regDstS,
  input  logic          id_aluSrcS,
  input  logic          id_dataMemReadS,
  input  logic          id_dataMemWriteS,
  input  logic          id_writeRegS,
  input  logic          id_memToRegS,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic [2:0]    ex_aluS,
  output logic          ex_regDstS,
  output logic          ex_aluSrcS,
  output logic          ex_dataMemReadS,
  output logic          ex_dataMemWriteS,
  output logic          ex_writeRegS,
  output logic          ex_memToRegS,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic          pc_write,
  output logic          ifid_write,
  output logic [CW-1:0] bubble_count
);

  logic rt_used;
  logic hz;
  logic bubble;
  logic ctl_en;

  // rt is a source for R-type ops (no immediate) and for stores (store data).
  assign rt_used = !id_aluSrcS | id_dataMemWriteS;

  assign hz = id_valid & ex_valid & ex_dataMemReadS & (ex_rt != '0) &
              ((ex_rt == id_rs) | (rt_used & (ex_rt == id_rt)));

  assign pc_write   = !(hz | hold);
  assign ifid_write = !(hz | hold);

  assign bubble = flush | hz;
  // Controls only propagate for a real, non-squashed instruction.
  assign ctl_en = !bubble & id_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid         <= 1'b0;
      ex_aluS          <= '0;
      ex_regDstS       <= 1'b0;
      ex_aluSrcS       <= 1'b0;
      ex_dataMemReadS  <= 1'b0;
      ex_dataMemWriteS <= 1'b0;
      ex_writeRegS     <= 1'b0;
      ex_memToRegS     <= 1'b0;
      ex_rs_data       <= '0;
      ex_rt_data       <= '0;
      ex_imm           <= '0;
      ex_pc4           <= '0;
      ex_rs            <= '0;
      ex_rt            <= '0;
      ex_rd            <= '0;
      bubble_count     <= '0;
    end else if (!hold) begin
      ex_valid         <= ctl_en;
      ex_aluS          <= ctl_en ? id_aluS : 3'b000;
      ex_regDstS       <= ctl_en & id_regDstS;
      ex_aluSrcS       <= ctl_en & id_aluSrcS;
      ex_dataMemReadS  <= ctl_en & id_dataMemReadS;
      ex_dataMemWriteS <= ctl_en & id_dataMemWriteS;
      ex_writeRegS     <= ctl_en & id_writeRegS;
      ex_memToRegS     <= ctl_en & id_memToRegS;
      ex_rs_data       <= id_rs_data;
      ex_rt_data       <= id_rt_data;
      ex_imm           <= id_imm;
      ex_pc4           <= id_pc4;
      ex_rs            <= id_rs;
      ex_rt            <= id_rt;
      ex_rd            <= id_rd;
      if (bubble && (bubble_count != {CW{1'b1}})) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end
  end

endmodule
